// File: rtl/regfile_pkg.sv
// Shared types for the register-file write path: address/data widths, the
// hard-wired zero register and the writeback request record.
package regfile_pkg;
    localparam int AW       = 5;
    localparam int DW       = 64;
    localparam int ZERO_REG = 31;
    localparam int CNT_W    = 16;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t rd;
        reg_data_t data;
    } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the request vector and
// a registered priority pointer that moves past the winner on advance.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win;
    logic          w_found;

    // Scan upward from the pointer, wrapping modulo NREQ; first request wins.
    always_comb begin
        grant   = '0;
        w_win   = r_ptr;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (int'(r_ptr) + i) % NREQ;
            if (!w_found && req[k]) begin
                grant[k] = 1'b1;
                w_win    = PW'(k);
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
        end
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: round-robin among writeback requesters,
// one-deep registered output stage, forwarding query and zero-register drop count.
module regfile_wr_arbiter #(
    parameter int NREQ     = 2,
    parameter int DW       = regfile_pkg::DW,
    parameter int AW       = regfile_pkg::AW,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0][AW-1:0]  req_reg,
    input  logic [NREQ-1:0][DW-1:0]  req_data,
    input  logic                     freeze,
    output logic                     RegWrite,
    output logic [AW-1:0]            WriteRegister,
    output logic [DW-1:0]            WriteData,
    input  logic [AW-1:0]            chk_reg,
    output logic                     chk_hit,
    output logic [DW-1:0]            chk_data,
    output logic [15:0]              drop_cnt
);
    import regfile_pkg::*;

    logic [NREQ-1:0] w_grant;
    logic [NREQ-1:0] w_ready;
    logic            w_xfer;
    wb_req_t         w_sel;
    logic            w_sel_zero;

    logic            r_we;
    reg_addr_t       r_wreg;
    reg_data_t       r_wdata;
    logic [15:0]     r_drop;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (w_xfer),
        .grant   (w_grant)
    );

    // Grant is only offered while out of reset and not frozen, so the pointer
    // cannot move on a cycle where nothing can be accepted.
    assign w_ready = (reset && !freeze) ? w_grant : '0;
    assign w_xfer  = |(req_valid & w_ready);

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                w_sel.rd   = req_reg[k];
                w_sel.data = req_data[k];
            end
        end
    end

    assign w_sel_zero = (w_sel.rd == AW'(ZERO_REG));

    // Zero-register writes are consumed here and never reach the regfile.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
            r_drop  <= '0;
        end else if (!freeze) begin
            if (!w_xfer) begin
                r_we <= 1'b0;
            end else if (w_sel_zero) begin
                r_we <= 1'b0;
                if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
            end else begin
                r_we    <= 1'b1;
                r_wreg  <= w_sel.rd;
                r_wdata <= w_sel.data;
            end
        end
    end

    assign req_ready     = w_ready;
    assign RegWrite      = r_we;
    assign WriteRegister = r_wreg;
    assign WriteData     = r_wdata;
    assign drop_cnt      = r_drop;
    assign chk_hit       = r_we && (chk_reg == r_wreg) && (chk_reg != AW'(ZERO_REG));
    assign chk_data      = r_wdata;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: scoreboard of accepted writes,
// round-robin reference, and a small regfile model fed by the write port.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    localparam int          N = 2;
    localparam logic [63:0] K = 64'h0000010204080001;

    logic                 clk;
    logic                 reset;
    logic                 freeze;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N-1:0][AW-1:0] req_reg;
    logic [N-1:0][DW-1:0] req_data;
    logic                 RegWrite;
    logic [AW-1:0]        WriteRegister;
    logic [DW-1:0]        WriteData;
    logic [AW-1:0]        chk_reg;
    logic                 chk_hit;
    logic [DW-1:0]        chk_data;
    logic [15:0]          drop_cnt;

    regfile_wr_arbiter #(.NREQ(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_reg       (req_reg),
        .req_data      (req_data),
        .freeze        (freeze),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .chk_reg       (chk_reg),
        .chk_hit       (chk_hit),
        .chk_data      (chk_data),
        .drop_cnt      (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tot = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tot++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    wb_req_t     lq0[$];
    wb_req_t     lq1[$];
    wb_req_t     sbq[$];
    int          logq[$];
    logic [63:0] mem[32];
    logic [N-1:0] acc = '0;
    bit          p_rst = 1'b1;
    bit          p_frz = 1'b0;
    bit          p_xfer = 1'b0;
    bit          p_zero = 1'b0;
    logic        m_we;
    logic [4:0]  m_reg;
    logic [63:0] m_data;
    logic [15:0] m_drop;
    int          m_ptr;
    int          viol = 0;
    logic [N-1:0] pv_pend = '0;
    wb_req_t     pv[N];
    int          ord[8] = '{1, 5, 2, 6, 3, 7, 4, 8};

    // Requester drivers: present queue head, retire it after a handshake.
    initial begin
        req_valid = '0;
        req_reg   = '0;
        req_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (acc[0] && lq0.size() != 0) lq0.delete(0);
            if (acc[1] && lq1.size() != 0) lq1.delete(0);
            req_valid[0] = (lq0.size() != 0);
            req_valid[1] = (lq1.size() != 0);
            if (lq0.size() != 0) begin req_reg[0] = lq0[0].rd; req_data[0] = lq0[0].data; end
            if (lq1.size() != 0) begin req_reg[1] = lq1[0].rd; req_data[1] = lq1[0].data; end
        end
    end

    // Reference model, evaluated mid-cycle: first resolve what the last edge
    // did, then predict the grant for the coming edge.
    initial begin
        logic [N-1:0] er;
        wb_req_t      e;
        int           w;
        m_we = 0; m_reg = 0; m_data = 0; m_drop = 0; m_ptr = 0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            if (p_rst) begin
                m_we = 0; m_reg = 0; m_data = 0; m_drop = 0; m_ptr = 0;
                sbq.delete();
            end else if (!p_frz) begin
                if (!p_xfer) m_we = 0;
                else if (p_zero) begin
                    m_we = 0;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end else if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    m_we = 1; m_reg = e.rd; m_data = e.data;
                end
            end
            check("regwrite", 64'(RegWrite), 64'(m_we));
            if (m_we) begin
                check("wreg", 64'(WriteRegister), 64'(m_reg));
                check("wdata", 64'(WriteData), m_data);
                check("fwd_data", 64'(chk_data), m_data);
            end
            check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            check("chk_hit", 64'(chk_hit), 64'(m_we && chk_reg == m_reg && chk_reg != 5'd31));

            er = '0; w = 0;
            if (reset && !freeze) begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_ptr + i) % N;
                    if (er == '0 && req_valid[k]) begin er[k] = 1'b1; w = k; end
                end
            end
            check("ready", 64'(req_ready), 64'(er));
            acc    = req_valid & req_ready;
            p_rst  = !reset;
            p_frz  = reset && freeze;
            p_xfer = (er != '0);
            p_zero = p_xfer && (req_reg[w] == 5'd31);
            if (p_xfer) begin
                if (!p_zero) begin
                    e.rd = req_reg[w]; e.data = req_data[w];
                    sbq.push_back(e);
                end
                m_ptr = (w + 1) % N;
            end

            for (int k = 0; k < N; k++) begin
                if (pv_pend[k] && (req_reg[k] !== pv[k].rd || req_data[k] !== pv[k].data)) viol++;
                pv_pend[k] = req_valid[k] && !acc[k];
                pv[k].rd   = req_reg[k];
                pv[k].data = req_data[k];
            end

            // The regfile captures on the next edge; reset on that edge cancels it.
            if (reset && RegWrite) begin
                mem[WriteRegister] = WriteData;
                logq.push_back(int'(WriteRegister));
            end
        end
    end

    task automatic push(input int lane, input int rd, input logic [63:0] d);
        wb_req_t e;
        e.rd = AW'(rd);
        e.data = d;
        if (lane == 0) lq0.push_back(e);
        else lq1.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((lq0.size() != 0 || lq1.size() != 0 || sbq.size() != 0) && n < 200) begin
            tick(1);
            n++;
        end
        check("drain", 64'(n < 200), 64'd1);
        tick(3);
    endtask

    task automatic wait_acc(input int lane);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!acc[lane] && n < 50);
        check("wait_acc", 64'(acc[lane]), 64'd1);
    endtask

    initial begin
        reset = 1'b0; freeze = 1'b0; chk_reg = '0;
        for (int i = 1; i <= 4; i++) push(0, i, 64'(i) * K);
        for (int i = 5; i <= 8; i++) push(1, i, 64'(i) * K);

        // reset held with both requesters valid
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_we", 64'(RegWrite), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        logq.delete();
        @(negedge clk); #1;
        check("first_grant", 64'(req_ready), 64'd1);
        drain();
        check("order_len", 64'(logq.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < logq.size()) check("order", 64'(logq[i]), 64'(ord[i]));
        for (int i = 1; i <= 8; i++) check("mem_rr", mem[i], 64'(i) * K);

        // zero register
        push(0, 31, 64'hA0);
        drain();
        check("drop_one", 64'(drop_cnt), 64'd1);
        check("x31_zero", mem[31], 64'd0);

        // freeze mid-stream
        push(0, 10, 64'(10) * K); push(0, 11, 64'(11) * K);
        push(1, 12, 64'(12) * K); push(1, 13, 64'(13) * K); push(1, 14, 64'(14) * K);
        tick(2);
        freeze = 1'b1;
        @(negedge clk); #1;
        check("frz_ready", 64'(req_ready), 64'd0);
        check("frz_we", 64'(RegWrite), 64'd1);
        tick(4);
        freeze = 1'b0;
        drain();
        for (int i = 10; i <= 14; i++) check("mem_frz", mem[i], 64'(i) * K);

        // forwarding against a held staged write
        push(0, 3, 64'hDEAD);
        wait_acc(0);
        @(posedge clk); #1;
        freeze = 1'b1;
        chk_reg = 5'd3;
        @(negedge clk); #1;
        check("fwd_hit3", 64'(chk_hit), 64'd1);
        check("fwd_dat3", 64'(chk_data), 64'hDEAD);
        chk_reg = 5'd4; #1;
        check("fwd_hit4", 64'(chk_hit), 64'd0);
        chk_reg = 5'd31; #1;
        check("fwd_hit31", 64'(chk_hit), 64'd0);
        @(posedge clk); #1;
        freeze = 1'b0;
        chk_reg = '0;
        tick(2);

        // reset while X9 is staged
        push(0, 9, 64'(9) * K);
        wait_acc(0);
        @(posedge clk); #1;
        reset = 1'b0;
        push(0, 20, 64'(20) * K);
        push(1, 21, 64'(21) * K);
        @(negedge clk); #1;
        check("mid_staged", 64'(RegWrite), 64'd1);
        check("mid_reg", 64'(WriteRegister), 64'd9);
        tick(2);
        reset = 1'b1;
        @(negedge clk); #1;
        check("ptr_zero", 64'(req_ready), 64'd1);
        drain();
        check("x9_dropped", mem[9], 64'd0);
        check("mem_20", mem[20], 64'(20) * K);
        check("mem_21", mem[21], 64'(21) * K);
        check("mem_3", mem[3], 64'hDEAD);

        check("sb_empty", 64'(sbq.size()), 64'd0);
        check("stable", 64'(viol), 64'd0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", tot, bad);
        $fatal(1);
    end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port among NREQ writeback requesters (ALU, load, multiply units, for example).
- Each requester uses a valid/ready handshake. The block picks one winner per cycle with round-robin priority.
- The winner is registered into a one-deep output stage that drives RegWrite, WriteRegister and WriteData of regfile directly.
- The block also exposes a forwarding query for the write currently in flight. Writes to register 31 are consumed but never issued.

Parameters:
- NREQ, 2, number of writeback requesters (2..8).
- DW, 64, data width.
- AW, 5, register address width.
- ZERO_REG, 31, hard-wired zero register index.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-low reset, sampled on posedge clk.
- req_valid  input  NREQ  per-requester write request.
- req_ready  output  NREQ  per-requester accept, combinational, one-hot or zero.
- req_reg  input  NREQ x AW  destination register per requester.
- req_data  input  NREQ x DW  write data per requester.
- freeze  input  1  pipeline freeze: no grants, output stage holds.
- RegWrite  output  1  write enable to regfile.
- WriteRegister  output  AW  write address to regfile.
- WriteData  output  DW  write data to regfile.
- chk_reg  input  AW  register being read this cycle.
- chk_hit  output  1  chk_reg matches the pending issued write.
- chk_data  output  DW  WriteData, valid when chk_hit.
- drop_cnt  output  16  count of accepted writes to ZERO_REG.

Behaviour:
- **Reset** (reset==0 at posedge):
  - RegWrite=0, WriteRegister=0, WriteData=0, drop_cnt=0.
  - Round-robin pointer = 0 (requester 0 has highest priority).
  - req_ready is forced to 0 while reset is low.
  - A reset arriving while a write is staged discards it; regfile is not written.
- **Arbitration:**
  - Combinational, from req_valid and the pointer.
  - Winner = first asserted req_valid at or after the pointer, scanning upward modulo NREQ.
  - req_ready[winner]=1 only if freeze==0 and reset==1. All other req_ready bits are 0.
  - A transfer occurs when req_valid[k] && req_ready[k] at posedge.
- **Pointer:**
  - After a transfer by requester k, the pointer becomes (k+1) mod NREQ.
  - Unchanged when there is no transfer.
- **Output stage:**
  - Transfer of a non-zero-register write: next cycle RegWrite=1, WriteRegister=req_reg[k], WriteData=req_data[k].
  - The regfile captures the write on the following posedge. Total latency from handshake to regfile update is 2 posedges.
  - Transfer with req_reg[k]==ZERO_REG: the request is accepted, next cycle RegWrite=0, and drop_cnt increments. drop_cnt saturates at 0xFFFF.
  - No transfer and freeze==0: next cycle RegWrite=0. WriteRegister and WriteData hold their values, which are don't-care.
  - freeze==1: RegWrite, WriteRegister and WriteData hold their current values. If RegWrite was 1 it stays 1, so the regfile rewrites the same value each cycle (idempotent).
- **Throughput:** one write per cycle sustained. There are no bubbles while any req_valid is high and freeze==0.
- **Forwarding:**
  - chk_hit = RegWrite && (chk_reg==WriteRegister) && (chk_reg!=ZERO_REG). Purely combinational.
  - chk_data = WriteData.
- **Requester rule:** once req_valid is asserted, req_reg and req_data must stay stable until accepted. The checker flags any violation.
- **Simultaneous events:**
  - All requesters valid: strict rotation 0,1,...,NREQ-1,0.
  - A single requester always valid and alone: it wins every cycle.
  - freeze and reset both active: reset wins.

Decomposition:
- Shared package regfile_pkg:
  - AW, DW and ZERO_REG constants.
  - typedef reg_addr_t (logic [AW-1:0]).
  - typedef reg_data_t (logic [DW-1:0]).
  - struct wb_req_t {reg_addr_t rd; reg_data_t data;}.
- Sub-module rr_arbiter:
  - Parameter NREQ; inputs req, advance, clk, reset; output one-hot grant.
  - Owns the pointer, which updates on advance.
  - Reused later for the read-port scheduler.

Test Plan:
- **Reset/idle:** hold reset=0 for 3 cycles with req_valid=2'b11 -> req_ready=0, RegWrite=0, drop_cnt=0. Release -> requester 0 granted first.
- **Round-robin:** both requesters valid continuously, r0 writes X1..X4, r1 writes X5..X8 -> regfile write order X1,X5,X2,X6,X3,X7,X4,X8 on consecutive cycles. Readback returns data i*64'h0000010204080001.
- **Zero register:** r0 writes X31=64'hA0 -> req_ready=1, RegWrite stays 0, drop_cnt=1. ReadData of X31=0.
- **Freeze:** freeze=1 for 4 cycles mid-stream with r1 valid -> no req_ready, staged write held. Release -> r1 accepted next cycle, no lost or duplicated writes.
- **Forwarding:** staged write X3=64'hDEAD and chk_reg=3 -> chk_hit=1, chk_data=64'hDEAD. chk_reg=4 or 31 -> chk_hit=0.
- **Reset mid-operation:** reset=0 while RegWrite=1 for X9 -> X9 is not written, pointer returns to 0.
